// File: rtl/adder_arb_rr.sv
// Round-robin arbiter sharing one Han-Carlson adder between NREQ requesters.
// The granted request's WIDTH+1-bit sum lands in a single registered output slot.

module adder_hca_r2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_cur;
  logic [WIDTH-1:0] p_cur;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] g_pre;

  assign p_bit = a ^ b;

  // Carry-in is folded into bit 0's generate, so prefix G[i] is the carry out of bit i.
  // Odd bits build full prefixes Kogge-Stone style; even bits finish in one last level.
  always_comb begin
    g_cur    = a & b;
    g_cur[0] = g_cur[0] | (p_bit[0] & ci);
    p_cur    = p_bit;
    g_nxt    = g_cur;
    p_nxt    = p_cur;
    for (int i = 1; i < WIDTH; i += 2) begin
      g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-1]);
      p_nxt[i] = p_cur[i] & p_cur[i-1];
    end
    g_cur = g_nxt;
    p_cur = p_nxt;
    for (int d = 2; d < WIDTH; d = d * 2) begin
      for (int i = 1; i < WIDTH; i += 2) begin
        if (i >= d) begin
          g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-d]);
          p_nxt[i] = p_cur[i] & p_cur[i-d];
        end
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    for (int i = 2; i < WIDTH; i += 2) begin
      g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-1]);
    end
    g_pre = g_nxt;
  end

  assign sum = {g_pre[WIDTH-1], p_bit ^ {g_pre[WIDTH-2:0], ci}};

endmodule

module adder_arb_rr #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       s_valid,
  output logic [NREQ-1:0]       s_ready,
  input  logic [NREQ*WIDTH-1:0] s_a,
  input  logic [NREQ*WIDTH-1:0] s_b,
  input  logic [NREQ-1:0]       s_ci,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH:0]        m_sum,
  output logic [IDW-1:0]        m_id
);

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH:0]   m_sum_q, m_sum_d;
  logic [IDW-1:0]   m_id_q, m_id_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  int               idx;
  logic             load_en;
  logic             take;
  logic [WIDTH:0]   add_sum;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = s_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = s_b[gi*WIDTH +: WIDTH];
  end

  // Circular scan starting at ptr; data inputs never feed this path.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && s_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign load_en = !m_valid_q || m_ready;
  assign take    = resetn && load_en && grant_vld;

  always_comb begin
    s_ready = '0;
    if (take) s_ready[grant_idx] = 1'b1;
  end

  adder_hca_r2 #(.WIDTH(WIDTH)) u_adder (
    .a   (a_arr[grant_idx]),
    .b   (b_arr[grant_idx]),
    .ci  (s_ci[grant_idx]),
    .sum (add_sum)
  );

  always_comb begin
    ptr_d     = ptr_q;
    m_valid_d = m_valid_q && !m_ready;
    m_sum_d   = m_sum_q;
    m_id_d    = m_id_q;
    if (take) begin
      m_valid_d = 1'b1;
      m_sum_d   = add_sum;
      m_id_d    = grant_idx;
      ptr_d     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q     <= '0;
      m_valid_q <= 1'b0;
      m_sum_q   <= '0;
      m_id_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      m_valid_q <= m_valid_d;
      m_sum_q   <= m_sum_d;
      m_id_q    <= m_id_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_sum   = m_sum_q;
  assign m_id    = m_id_q;

endmodule
